// File: rtl/serial_word_matcher.sv
// Bit-serial word-equality checker: folds x XNOR y over WIDTH bits and reports
// whole-word match, first-mismatch arrival index and a saturating matched-word count.
module serial_word_matcher #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             x,
  input  logic             y,
  input  logic             clr_count,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [IDX_W-1:0] mismatch_idx,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [IDX_W:0]   LAST_BIT = (IDX_W+1)'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_REPORT
  } state_t;

  state_t           state_q;
  logic [IDX_W:0]   bit_cnt_q;
  logic             eq_acc_q;
  logic [IDX_W-1:0] first_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             match_q;
  logic [IDX_W-1:0] mismatch_idx_q;
  logic [CNT_W-1:0] match_count_q;

  logic             bit_eq;
  logic             eq_acc_d;
  logic [IDX_W-1:0] first_idx_d;
  logic             last_bit;
  logic             consume;
  logic             word_end;
  logic [CNT_W-1:0] match_count_d;

  always_comb begin
    bit_eq      = ~(x ^ y);
    eq_acc_d    = eq_acc_q & bit_eq;
    // Only the first falling edge of the accumulator captures the index.
    first_idx_d = (eq_acc_q && !bit_eq) ? bit_cnt_q[IDX_W-1:0] : first_idx_q;
    last_bit    = (bit_cnt_q == LAST_BIT);
    consume     = (state_q == S_SHIFT) && bit_valid;
    word_end    = consume && last_bit;

    match_count_d = match_count_q;
    if (word_end && eq_acc_d && (match_count_q != CNT_MAX)) begin
      match_count_d = match_count_q + 1'b1;
    end
    if (clr_count) begin
      match_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      eq_acc_q       <= 1'b1;
      first_idx_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      match_q        <= 1'b0;
      mismatch_idx_q <= '0;
      match_count_q  <= '0;
    end else begin
      done_q        <= 1'b0;
      match_count_q <= match_count_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_SHIFT;
            busy_q      <= 1'b1;
            bit_cnt_q   <= '0;
            eq_acc_q    <= 1'b1;
            first_idx_q <= '0;
          end
        end
        S_SHIFT: begin
          if (consume) begin
            eq_acc_q    <= eq_acc_d;
            first_idx_q <= first_idx_d;
            bit_cnt_q   <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              state_q        <= S_REPORT;
              done_q         <= 1'b1;
              match_q        <= eq_acc_d;
              mismatch_idx_q <= eq_acc_d ? '0 : first_idx_d;
            end
          end
        end
        S_REPORT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign match        = match_q;
  assign mismatch_idx = mismatch_idx_q;
  assign match_count  = match_count_q;

endmodule

// File: tb/tb_serial_word_matcher.sv
// Directed bench for serial_word_matcher (WIDTH=8, CNT_W=2 so saturation is reachable).
module tb_serial_word_matcher;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bit_valid;
  logic       x;
  logic       y;
  logic       clr_count;
  logic       busy;
  logic       done;
  logic       match;
  logic [2:0] mismatch_idx;
  logic [1:0] match_count;

  int tests = 0;
  int fails = 0;

  serial_word_matcher #(
    .WIDTH(8),
    .CNT_W(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bit_valid   (bit_valid),
    .x           (x),
    .y           (y),
    .clr_count   (clr_count),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .mismatch_idx(mismatch_idx),
    .match_count (match_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word; arrival index i carries xv[i]/yv[i].
  task automatic do_word(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                         input bit stall, input bit mid_start, input bit clr_last,
                         input logic exp_match, input logic [2:0] exp_idx,
                         input logic [1:0] exp_cnt);
    // Unequal bit offered with start must be ignored in IDLE.
    start = 1'b1; bit_valid = 1'b1; x = 1'b1; y = 1'b0;
    tick();
    start = 1'b0;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      x = xv[i];
      y = yv[i];
      clr_count = clr_last && (i == 7);
      tick();
      clr_count = 1'b0;
      if (i < 7) begin
        check({tag, " done_early"}, 32'(done), 32'd0);
        if (stall) begin
          bit_valid = 1'b0; x = 1'b1; y = 1'b0;
          start = mid_start && (i == 3);
          tick();
          start = 1'b0;
          check({tag, " stall_busy"}, 32'(busy), 32'd1);
          check({tag, " stall_done"}, 32'(done), 32'd0);
        end
      end
    end
    bit_valid = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_report"}, 32'(busy), 32'd1);
    check({tag, " match"}, 32'(match), 32'(exp_match));
    check({tag, " idx"}, 32'(mismatch_idx), 32'(exp_idx));
    check({tag, " count"}, 32'(match_count), 32'(exp_cnt));
    $display("[TB] %s: x=%02h y=%02h match=%0d idx=%0d count=%0d", tag, xv, yv,
             match, mismatch_idx, match_count);
    tick();
    check({tag, " done_fall"}, 32'(done), 32'd0);
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
    check({tag, " match_hold"}, 32'(match), 32'(exp_match));
    check({tag, " idx_hold"}, 32'(mismatch_idx), 32'(exp_idx));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; x = 1'b0; y = 1'b0; clr_count = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset match", 32'(match), 32'd0);
    check("reset idx", 32'(mismatch_idx), 32'd0);
    check("reset count", 32'(match_count), 32'd0);
    rst = 1'b0;
    tick();

    // Arrival pattern 1,0,1,0,0,1,0,1 -> 8'hA5; y inverted at bits 3 and 6 -> 8'hED.
    do_word("full_match", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd1);
    do_word("multi_mm", 8'hA5, 8'hED, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd1);
    do_word("stalls", 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 2'd2);

    // Reset mid-word: outputs clear asynchronously, no report follows.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; x = i[0]; y = i[0];
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid done", 32'(done), 32'd0);
    check("rst_mid match", 32'(match), 32'd0);
    check("rst_mid idx", 32'(mismatch_idx), 32'd0);
    check("rst_mid count", 32'(match_count), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_mid no_done", 32'(done), 32'd0);
    end
    bit_valid = 1'b0;
    tick();
    do_word("after_rst", 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd1);
    do_word("idx_restart", 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd1);
    do_word("last_bit", 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 2'd1);

    // Saturation with CNT_W=2, then clear colliding with an increment.
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_idle count", 32'(match_count), 32'd0);
    do_word("sat1", 8'h11, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd1);
    do_word("sat2", 8'h22, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd2);
    do_word("sat3", 8'h33, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd3);
    do_word("sat4", 8'h44, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd3);
    do_word("sat5", 8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd3);
    do_word("clr_vs_inc", 8'h66, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
